// File: rtl/clksplt_pkg.sv
// Shared types and helpers for the clock-splitter pulse arbiter.
// State encoding and index-width helper.
package clksplt_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clksplt_rr_pick.sv
// Combinational round-robin picker: lowest set request
// at or after ptr, searching cyclically.
module clksplt_rr_pick
  import clksplt_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] dbl;
  int k;
  int t;

  // Rotate so bit 0 is the ptr position, then find the first set bit.
  always_comb begin
    dbl   = {req, req} >> ptr;
    found = 1'b0;
    k     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (dbl[i]) begin
        found = 1'b1;
        k     = i;
      end
    end
    t = int'(ptr) + k;
    if (t >= N) t = t - N;
    idx = IW'(t);
  end

endmodule

// File: rtl/clksplt_pulse_arbiter.sv
// Round-robin arbiter sharing one RSFQ splitter root; edge-encoded
// drive, minimum issue spacing and latency-tracked completions.
module clksplt_pulse_arbiter
  import clksplt_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MIN_GAP = 2,
  parameter int LAT     = 3,
  parameter int CW      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             a_tgl,
  output logic [N_REQ-1:0] done,
  output logic             busy,
  output logic [CW-1:0]    pulse_cnt
);

  localparam int IW = idx_w(N_REQ);
  localparam int GW = (MIN_GAP > 2) ? $clog2(MIN_GAP) : 1;
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  state_e           state_q;
  logic [GW-1:0]    gap_q;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    ptr_d;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] done_q;
  logic             tgl_q;
  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [LAT-1:0]   vld_q;
  logic [LAT-1:0]   vld_d;
  logic [IW-1:0]    id_q [LAT];

  logic          found;
  logic [IW-1:0] win;
  logic          take;
  logic          hold_d;

  clksplt_rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (found),
    .idx   (win)
  );

  assign take = (state_q == IDLE) && en && found;

  always_comb begin
    ptr_d = ptr_q;
    if (take) begin
      ptr_d = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
    end
    if (take) hold_d = (MIN_GAP > 1);
    else hold_d = (state_q == HOLD) && (gap_q != GW'(1));
    vld_d    = '0;
    vld_d[0] = take;
    for (int s = 1; s < LAT; s++) vld_d[s] = vld_q[s-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      tgl_q   <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      vld_q   <= '0;
      for (int s = 0; s < LAT; s++) id_q[s] <= '0;
    end else begin
      state_q <= hold_d ? HOLD : IDLE;
      if (take) gap_q <= GW'(MIN_GAP - 1);
      else if (state_q == HOLD) gap_q <= gap_q - 1'b1;
      gnt_q <= take ? (ONE << win) : '0;
      if (take) begin
        tgl_q <= ~tgl_q;
        cnt_q <= cnt_q + 1'b1;
      end
      ptr_q   <= ptr_d;
      vld_q   <= vld_d;
      id_q[0] <= win;
      for (int s = 1; s < LAT; s++) id_q[s] <= id_q[s-1];
      // The oldest stage retires into a one-hot completion.
      done_q <= vld_q[LAT-1] ? (ONE << id_q[LAT-1]) : '0;
      busy_q <= hold_d | (|vld_d);
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign a_tgl     = tgl_q;
  assign busy      = busy_q;
  assign pulse_cnt = cnt_q;

endmodule

// File: doc/clksplt_pulse_arbiter.md
# clksplt_pulse_arbiter

Synchronous controller that shares a single RSFQ clock-splitter tree root among several requesters. It arbitrates pending pulse requests round-robin and drives the splitter root input in edge (toggle) encoding, one edge per issued pulse. It enforces a minimum issue spacing that reflects the splitter's 7.0 ps self-recovery time, and reports per-requester completion once the splitter propagation latency has elapsed. It sits between conventional clocked control logic and the behavioural splitter cell models in the cell-library simulation environment.

## Interface
Parameters:
- N_REQ, 4, number of requesters, legal 2..16
- MIN_GAP, 2, minimum cycles between consecutive grants, legal ≥1
- LAT, 3, cycles from grant to completion, legal ≥1
- CW, 16, width of issued-pulse counter

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset; synchronous, active-high
- en  in  1  arbitration enable; low blocks new grants only
- req  in  N_REQ  level request per requester, held until granted
- gnt  out  N_REQ  one-hot, one-cycle grant
- a_tgl  out  1  splitter root drive; toggles once per grant (each edge = one pulse)
- done  out  N_REQ  one-hot, one-cycle completion to the originating requester
- busy  out  1  high while holdoff is active or any pulse is in flight
- pulse_cnt  out  CW  total grants issued, wraps 2^CW−1 → 0

## Operation
- FSM states: IDLE (grant permitted) and HOLD (spacing holdoff).
- In IDLE, with en=1 and req≠0 sampled at edge k:
  - gnt[w] is high during cycle k+1.
  - a_tgl inverts and pulse_cnt increments at the same edge.
  - w is the lowest set req index at or after ptr, searching cyclically.
  - ptr ← (w+1) mod N_REQ.
- After a grant with MIN_GAP=1: stay in IDLE; grants may occur every cycle.
- After a grant with MIN_GAP>1:
  - Enter HOLD with gap counter = MIN_GAP−1.
  - Decrement each cycle; return to IDLE at the edge where the counter reaches 0.
  - The next grant can therefore occur no earlier than MIN_GAP cycles after the previous one.
- In HOLD, req is ignored. Requests are not latched; a requester that drops req before being granted is forgotten.
- en=0:
  - No grants are issued and ptr is frozen.
  - HOLD continues counting.
  - In-flight pulses complete normally.
- In-flight tracking:
  - LAT-deep shift register of {valid, id}, loaded at each grant.
  - done[id] asserts exactly LAT cycles after the gnt cycle.
  - Multiple pulses in flight are supported. Completions stay ordered and never collide, because at most one grant occurs per cycle.
- busy = (state==HOLD) | (any in-flight valid).
- Reset values (from the first edge with rst=1):
  - gnt=0, done=0, a_tgl=0, busy=0, pulse_cnt=0.
  - ptr=0, state=IDLE, in-flight cleared.
- Reset mid-operation discards all in-flight pulses: no done is ever produced for them.
- rst has priority over all other inputs.

## Timing
- Request-to-grant latency: 1 cycle when in IDLE.
- Grant-to-done latency: exactly LAT cycles.
- Grant spacing: at least MIN_GAP cycles.
- All outputs are registered; there are no combinational input-to-output paths.
- a_tgl changes only on grant edges, and it never toggles twice within MIN_GAP cycles.

## Structure
- Shared package clksplt_pkg holds:
  - the state enum (IDLE, HOLD);
  - a localparam-width helper for the ptr/id width ($clog2(N_REQ)).
- One sub-module, clksplt_rr_pick: combinational round-robin picker.
  - Inputs: req and ptr.
  - Outputs: a found flag and the winning index.
- The in-flight shift register and the FSM live in the top module.

## Test plan
- Reset, then req=4'b0001, en=1, default parameters:
  - gnt=0001 one cycle after req is sampled, a_tgl 0→1.
  - done=0001 three cycles after gnt; pulse_cnt=1; busy falls after done.
- req=4'b1111 held, MIN_GAP=2:
  - Grants rotate 0001, 0010, 0100, 1000, 0001 on every second cycle.
  - a_tgl toggles at each grant; done follows each grant by 3 cycles.
- MIN_GAP=1, req=4'b1010 held: grants alternate 0010, 1000 on consecutive cycles; done pulses are back-to-back and ordered.
- en=0 while req=4'b0100:
  - No grant and no a_tgl change for 10 cycles.
  - Raising en produces a grant of 0100 one cycle later.
- rst=1 asserted one cycle after a grant:
  - All outputs are 0 on the next cycle.
  - No done appears within 10 cycles; a subsequent grant starts from ptr=0.
- CW=4, 17 grants: pulse_cnt wraps 15→0→1.
